// File: rtl/l2_output_encoder_pkg.sv
// Shared types and defaults for the L2 outbound message encoder.
// Payload structs carry only the fields meaningful on each channel.
package l2_output_encoder_pkg;

   localparam int L2_OUT_QDEPTH = 2;

   typedef logic [1:0]   mix_msg_t;
   typedef logic         hprot_t;
   typedef logic [27:0]  line_addr_t;
   typedef logic [127:0] line_t;
   typedef logic [3:0]   word_mask_t;
   typedef logic [3:0]   cache_id_t;

   typedef enum logic [1:0] {
      DST_REQ    = 2'd0,
      DST_RSP    = 2'd1,
      DST_RD_RSP = 2'd2,
      DST_INVAL  = 2'd3
   } l2_out_dst_t;

   typedef struct packed {
      mix_msg_t   coh_msg;
      hprot_t     hprot;
      line_addr_t addr;
      line_t      line;
      word_mask_t word_mask;
   } l2_req_out_t;

   typedef struct packed {
      mix_msg_t   coh_msg;
      cache_id_t  req_id;
      logic       to_req;
      line_addr_t addr;
      line_t      line;
      word_mask_t word_mask;
   } l2_rsp_out_t;

   typedef struct packed {
      line_t line;
   } l2_rd_rsp_t;

   typedef struct packed {
      line_addr_t addr;
      hprot_t     hprot;
   } l2_inval_t;

endpackage

// File: rtl/l2_out_fifo.sv
// Per-channel circular FIFO with occupancy count; full is judged on the
// registered count, so a push into a full queue is refused even if it pops.
module l2_out_fifo #(
   parameter type T        = logic,
   parameter int  DEPTH    = 2,
   parameter int  CNT_BITS = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  T                    push_data,
   input  logic                pop,
   output T                    out_data,
   output logic                out_valid,
   output logic                full,
   output logic [CNT_BITS-1:0] count,
   output logic [CNT_BITS-1:0] count_next
);

   localparam int                  PW      = CNT_BITS - 1;
   localparam logic [PW-1:0]       PTR_ONE = PW'(1'b1);
   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1'b1);
   localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEPTH);

   T                    mem_q [DEPTH];
   T                    mem_d [DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0] count_q, count_d;
   logic                push_en_s, pop_en_s;

   assign full       = (count_q == CNT_MAX);
   assign out_valid  = (count_q != '0);
   assign out_data   = mem_q[rd_ptr_q];
   assign count      = count_q;
   assign count_next = count_d;
   assign push_en_s  = push & ~full;
   assign pop_en_s   = pop & out_valid;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_en_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_en_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_en_s, pop_en_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/l2_output_encoder.sv
// Routes controller pushes into four independent outbound channel FIFOs and
// reports backpressure, drain status and a sticky overflow flag.
module l2_output_encoder
   import l2_output_encoder_pkg::*;
#(
   parameter int QDEPTH   = L2_OUT_QDEPTH,
   parameter int CNT_BITS = $clog2(QDEPTH) + 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_valid,
   input  l2_out_dst_t push_dst,
   input  mix_msg_t    push_coh_msg,
   input  hprot_t      push_hprot,
   input  line_addr_t  push_addr,
   input  line_t       push_line,
   input  word_mask_t  push_word_mask,
   input  cache_id_t   push_req_id,
   input  logic        push_to_req,
   output logic        encoder_ready,
   output logic        out_drained,
   output logic        push_overflow,
   output logic        l2_req_out_valid,
   input  logic        l2_req_out_ready,
   output l2_req_out_t l2_req_out_data,
   output logic        l2_rsp_out_valid,
   input  logic        l2_rsp_out_ready,
   output l2_rsp_out_t l2_rsp_out_data,
   output logic        l2_rd_rsp_valid,
   input  logic        l2_rd_rsp_ready,
   output l2_rd_rsp_t  l2_rd_rsp_data,
   output logic        l2_inval_valid,
   input  logic        l2_inval_ready,
   output l2_inval_t   l2_inval_data
);

   logic [3:0]          push_sel_s, full_s;
   logic [CNT_BITS-1:0] cnt_s [4];
   logic [CNT_BITS-1:0] cnt_next_s [4];
   l2_req_out_t         req_pl_s;
   l2_rsp_out_t         rsp_pl_s;
   l2_rd_rsp_t          rd_pl_s;
   l2_inval_t           inv_pl_s;
   logic                drained_q, drained_d, overflow_q, overflow_d;

   assign push_sel_s = push_valid ? (4'b0001 << push_dst) : 4'b0000;

   // Channel payloads keep only their own fields; everything else reads as zero.
   always_comb begin
      req_pl_s = '{coh_msg: push_coh_msg, hprot: push_hprot, addr: push_addr,
                   line: push_line, word_mask: push_word_mask};
      rsp_pl_s = '{coh_msg: push_coh_msg, req_id: push_req_id, to_req: push_to_req,
                   addr: push_addr, line: push_line, word_mask: push_word_mask};
      rd_pl_s  = '{line: push_line};
      inv_pl_s = '{addr: push_addr, hprot: push_hprot};
   end

   l2_out_fifo #(.T(l2_req_out_t), .DEPTH(QDEPTH), .CNT_BITS(CNT_BITS)) u_req_fifo (
      .clk(clk), .rst(rst), .push(push_sel_s[0]), .push_data(req_pl_s),
      .pop(l2_req_out_ready), .out_data(l2_req_out_data), .out_valid(l2_req_out_valid),
      .full(full_s[0]), .count(cnt_s[0]), .count_next(cnt_next_s[0]));

   l2_out_fifo #(.T(l2_rsp_out_t), .DEPTH(QDEPTH), .CNT_BITS(CNT_BITS)) u_rsp_fifo (
      .clk(clk), .rst(rst), .push(push_sel_s[1]), .push_data(rsp_pl_s),
      .pop(l2_rsp_out_ready), .out_data(l2_rsp_out_data), .out_valid(l2_rsp_out_valid),
      .full(full_s[1]), .count(cnt_s[1]), .count_next(cnt_next_s[1]));

   l2_out_fifo #(.T(l2_rd_rsp_t), .DEPTH(QDEPTH), .CNT_BITS(CNT_BITS)) u_rd_fifo (
      .clk(clk), .rst(rst), .push(push_sel_s[2]), .push_data(rd_pl_s),
      .pop(l2_rd_rsp_ready), .out_data(l2_rd_rsp_data), .out_valid(l2_rd_rsp_valid),
      .full(full_s[2]), .count(cnt_s[2]), .count_next(cnt_next_s[2]));

   l2_out_fifo #(.T(l2_inval_t), .DEPTH(QDEPTH), .CNT_BITS(CNT_BITS)) u_inv_fifo (
      .clk(clk), .rst(rst), .push(push_sel_s[3]), .push_data(inv_pl_s),
      .pop(l2_inval_ready), .out_data(l2_inval_data), .out_valid(l2_inval_valid),
      .full(full_s[3]), .count(cnt_s[3]), .count_next(cnt_next_s[3]));

   // Backpressure comes from registered counts only, never same-cycle pops.
   assign encoder_ready = ~|full_s;
   assign out_drained   = drained_q;
   assign push_overflow = overflow_q;

   always_comb begin
      drained_d  = (cnt_next_s[0] == '0) && (cnt_next_s[1] == '0) &&
                   (cnt_next_s[2] == '0) && (cnt_next_s[3] == '0);
      overflow_d = overflow_q | (|(push_sel_s & full_s));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drained_q  <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         drained_q  <= drained_d;
         overflow_q <= overflow_d;
      end
   end

   logic unused_cnt_s;
   assign unused_cnt_s = ^{cnt_s[0], cnt_s[1], cnt_s[2], cnt_s[3]};

endmodule

// File: tb/tb_l2_output_encoder.sv
// Directed and scoreboard-driven bench for the L2 outbound encoder.
module tb_l2_output_encoder;
   import l2_output_encoder_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        push_valid = 1'b0;
   l2_out_dst_t push_dst = DST_REQ;
   mix_msg_t    push_coh_msg = '0;
   hprot_t      push_hprot = '0;
   line_addr_t  push_addr = '0;
   line_t       push_line = '0;
   word_mask_t  push_word_mask = '0;
   cache_id_t   push_req_id = '0;
   logic        push_to_req = 1'b0;
   logic        encoder_ready, out_drained, push_overflow;
   logic        req_v, rsp_v, rd_v, inv_v;
   logic        req_r = 1'b0, rsp_r = 1'b0, rd_r = 1'b0, inv_r = 1'b0;
   l2_req_out_t req_d;
   l2_rsp_out_t rsp_d;
   l2_rd_rsp_t  rd_d;
   l2_inval_t   inv_d;

   int chk_cnt = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   l2_output_encoder dut (
      .clk(clk), .rst(rst), .push_valid(push_valid), .push_dst(push_dst),
      .push_coh_msg(push_coh_msg), .push_hprot(push_hprot), .push_addr(push_addr),
      .push_line(push_line), .push_word_mask(push_word_mask), .push_req_id(push_req_id),
      .push_to_req(push_to_req), .encoder_ready(encoder_ready), .out_drained(out_drained),
      .push_overflow(push_overflow),
      .l2_req_out_valid(req_v), .l2_req_out_ready(req_r), .l2_req_out_data(req_d),
      .l2_rsp_out_valid(rsp_v), .l2_rsp_out_ready(rsp_r), .l2_rsp_out_data(rsp_d),
      .l2_rd_rsp_valid(rd_v), .l2_rd_rsp_ready(rd_r), .l2_rd_rsp_data(rd_d),
      .l2_inval_valid(inv_v), .l2_inval_ready(inv_r), .l2_inval_data(inv_d));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_push(input l2_out_dst_t dst, input mix_msg_t coh, input hprot_t hp,
                          input line_addr_t addr, input line_t line, input word_mask_t wm,
                          input cache_id_t id, input logic to_req);
      push_valid = 1'b1; push_dst = dst; push_coh_msg = coh; push_hprot = hp;
      push_addr = addr; push_line = line; push_word_mask = wm; push_req_id = id;
      push_to_req = to_req;
   endtask

   task automatic idle();
      push_valid = 1'b0;
   endtask

   task automatic set_readies(input logic [3:0] r);
      {inv_r, rd_r, rsp_r, req_r} = r;
   endtask

   task automatic do_reset();
      rst = 1'b0; idle(); set_readies(4'b0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      chk_cnt++; if (encoder_ready !== 1'b1) $display("FAIL reset_enc_ready: got %b exp 1", encoder_ready); else pass_cnt++;
      chk_cnt++; if (out_drained !== 1'b1) $display("FAIL reset_drained: got %b exp 1", out_drained); else pass_cnt++;
      chk_cnt++; if (push_overflow !== 1'b0) $display("FAIL reset_overflow: got %b exp 0", push_overflow); else pass_cnt++;
      chk_cnt++; if ({req_v, rsp_v, rd_v, inv_v} !== 4'b0000) $display("FAIL reset_valids: got %b exp 0000", {req_v, rsp_v, rd_v, inv_v}); else pass_cnt++;
      chk_cnt++; if ((req_d !== '0) || (rsp_d !== '0) || (rd_d !== '0) || (inv_d !== '0)) $display("FAIL reset_data: got nonzero exp 0"); else pass_cnt++;
   endtask

   task automatic test_basic_req();
      l2_req_out_t exp;
      exp = '{coh_msg: 2'd1, hprot: 1'b1, addr: 28'h1234, line: 128'hDEAD_BEEF, word_mask: 4'hA};
      do_push(DST_REQ, 2'd1, 1'b1, 28'h1234, 128'hDEAD_BEEF, 4'hA, 4'd9, 1'b1);
      step();
      idle();
      chk_cnt++; if (req_v !== 1'b1) $display("FAIL basic_valid: got %b exp 1", req_v); else pass_cnt++;
      chk_cnt++; if (req_d !== exp) $display("FAIL basic_data: got %h exp %h", req_d, exp); else pass_cnt++;
      chk_cnt++; if (out_drained !== 1'b0) $display("FAIL basic_drained: got %b exp 0", out_drained); else pass_cnt++;
      chk_cnt++; if ({rsp_v, rd_v, inv_v} !== 3'b000) $display("FAIL basic_other_valids: got %b exp 000", {rsp_v, rd_v, inv_v}); else pass_cnt++;
      req_r = 1'b1;
      step();
      req_r = 1'b0;
      chk_cnt++; if (req_v !== 1'b0) $display("FAIL basic_popped: got %b exp 0", req_v); else pass_cnt++;
      chk_cnt++; if (out_drained !== 1'b1) $display("FAIL basic_drained_back: got %b exp 1", out_drained); else pass_cnt++;
   endtask

   task automatic test_rsp_backpressure();
      do_push(DST_RSP, 2'd2, 1'b0, 28'h10, 128'h1, 4'h3, 4'd3, 1'b1);
      step();
      do_push(DST_RSP, 2'd2, 1'b0, 28'h20, 128'h2, 4'h3, 4'd5, 1'b0);
      step();
      idle();
      chk_cnt++; if (encoder_ready !== 1'b0) $display("FAIL bp_enc_ready_full: got %b exp 0", encoder_ready); else pass_cnt++;
      chk_cnt++; if (rsp_d.req_id !== 4'd3) $display("FAIL bp_first_id: got %0d exp 3", rsp_d.req_id); else pass_cnt++;
      chk_cnt++; if (rsp_d.to_req !== 1'b1) $display("FAIL bp_first_to_req: got %b exp 1", rsp_d.to_req); else pass_cnt++;
      rsp_r = 1'b1;
      step();
      chk_cnt++; if (encoder_ready !== 1'b1) $display("FAIL bp_enc_ready_after_pop: got %b exp 1", encoder_ready); else pass_cnt++;
      chk_cnt++; if (rsp_d.req_id !== 4'd5) $display("FAIL bp_second_id: got %0d exp 5", rsp_d.req_id); else pass_cnt++;
      chk_cnt++; if (rsp_d.addr !== 28'h20) $display("FAIL bp_second_addr: got %h exp 20", rsp_d.addr); else pass_cnt++;
      step();
      rsp_r = 1'b0;
      chk_cnt++; if (rsp_v !== 1'b0) $display("FAIL bp_empty: got %b exp 0", rsp_v); else pass_cnt++;
   endtask

   task automatic test_overflow();
      do_push(DST_RSP, 2'd0, 1'b0, 28'h7, 128'h7, 4'h1, 4'd7, 1'b0);
      step();
      do_push(DST_RSP, 2'd0, 1'b0, 28'h9, 128'h9, 4'h1, 4'd9, 1'b0);
      step();
      do_push(DST_RSP, 2'd0, 1'b0, 28'hB, 128'hB, 4'h1, 4'd11, 1'b0);
      rsp_r = 1'b1;
      step();
      idle();
      rsp_r = 1'b0;
      chk_cnt++; if (push_overflow !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", push_overflow); else pass_cnt++;
      chk_cnt++; if (rsp_d.req_id !== 4'd9) $display("FAIL ovf_head_id: got %0d exp 9", rsp_d.req_id); else pass_cnt++;
      chk_cnt++; if (encoder_ready !== 1'b1) $display("FAIL ovf_count_one: got %b exp 1", encoder_ready); else pass_cnt++;
      rsp_r = 1'b1;
      step();
      rsp_r = 1'b0;
      chk_cnt++; if (rsp_v !== 1'b0) $display("FAIL ovf_dropped: got %b exp 0", rsp_v); else pass_cnt++;
      chk_cnt++; if (push_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b exp 1", push_overflow); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      set_readies(4'b1111);
      do_push(DST_RD_RSP, 2'd3, 1'b1, 28'h55, 128'hA5A5, 4'hF, 4'd1, 1'b1);
      step();
      do_push(DST_INVAL, 2'd3, 1'b1, 28'h66, 128'h5A5A, 4'hF, 4'd1, 1'b1);
      chk_cnt++; if ({req_v, rsp_v, rd_v, inv_v} !== 4'b0010) $display("FAIL b2b_c1_valids: got %b exp 0010", {req_v, rsp_v, rd_v, inv_v}); else pass_cnt++;
      chk_cnt++; if (rd_d.line !== 128'hA5A5) $display("FAIL b2b_rd_line: got %h exp a5a5", rd_d.line); else pass_cnt++;
      step();
      do_push(DST_REQ, 2'd1, 1'b0, 28'h77, 128'h1234, 4'h5, 4'd1, 1'b1);
      chk_cnt++; if ({req_v, rsp_v, rd_v, inv_v} !== 4'b0001) $display("FAIL b2b_c2_valids: got %b exp 0001", {req_v, rsp_v, rd_v, inv_v}); else pass_cnt++;
      chk_cnt++; if (inv_d !== '{addr: 28'h66, hprot: 1'b1}) $display("FAIL b2b_inval_data: got %h exp 0000066_1", inv_d); else pass_cnt++;
      step();
      idle();
      chk_cnt++; if ({req_v, rsp_v, rd_v, inv_v} !== 4'b1000) $display("FAIL b2b_c3_valids: got %b exp 1000", {req_v, rsp_v, rd_v, inv_v}); else pass_cnt++;
      chk_cnt++; if (req_d.addr !== 28'h77) $display("FAIL b2b_req_addr: got %h exp 77", req_d.addr); else pass_cnt++;
      chk_cnt++; if (out_drained !== 1'b0) $display("FAIL b2b_not_drained: got %b exp 0", out_drained); else pass_cnt++;
      step();
      chk_cnt++; if ({req_v, rsp_v, rd_v, inv_v} !== 4'b0000) $display("FAIL b2b_c4_valids: got %b exp 0000", {req_v, rsp_v, rd_v, inv_v}); else pass_cnt++;
      chk_cnt++; if (out_drained !== 1'b1) $display("FAIL b2b_drained: got %b exp 1", out_drained); else pass_cnt++;
      set_readies(4'b0000);
   endtask

   task automatic test_random();
      l2_req_out_t q_req[$];
      l2_rsp_out_t q_rsp[$];
      l2_rd_rsp_t  q_rd[$];
      l2_inval_t   q_inv[$];
      int pushes = 0;
      int cyc = 0;
      l2_out_dst_t dst;
      mix_msg_t coh; hprot_t hp; line_addr_t addr; line_t line; word_mask_t wm; cache_id_t id; logic tr;
      while ((pushes < 1000 || q_req.size() + q_rsp.size() + q_rd.size() + q_inv.size() != 0) && cyc < 20000) begin
         if (pushes < 1000) set_readies(4'($urandom_range(0, 15)));
         else set_readies(4'b1111);
         chk_cnt++; if (req_v !== (q_req.size() != 0)) $display("FAIL rnd_req_valid: got %b exp %b", req_v, q_req.size() != 0); else pass_cnt++;
         chk_cnt++; if (rsp_v !== (q_rsp.size() != 0)) $display("FAIL rnd_rsp_valid: got %b exp %b", rsp_v, q_rsp.size() != 0); else pass_cnt++;
         chk_cnt++; if (rd_v !== (q_rd.size() != 0)) $display("FAIL rnd_rd_valid: got %b exp %b", rd_v, q_rd.size() != 0); else pass_cnt++;
         chk_cnt++; if (inv_v !== (q_inv.size() != 0)) $display("FAIL rnd_inv_valid: got %b exp %b", inv_v, q_inv.size() != 0); else pass_cnt++;
         if (req_v && req_r && q_req.size() != 0) begin
            chk_cnt++; if (req_d !== q_req[0]) $display("FAIL rnd_req_data: got %h exp %h", req_d, q_req[0]); else pass_cnt++;
            void'(q_req.pop_front());
         end
         if (rsp_v && rsp_r && q_rsp.size() != 0) begin
            chk_cnt++; if (rsp_d !== q_rsp[0]) $display("FAIL rnd_rsp_data: got %h exp %h", rsp_d, q_rsp[0]); else pass_cnt++;
            void'(q_rsp.pop_front());
         end
         if (rd_v && rd_r && q_rd.size() != 0) begin
            chk_cnt++; if (rd_d !== q_rd[0]) $display("FAIL rnd_rd_data: got %h exp %h", rd_d, q_rd[0]); else pass_cnt++;
            void'(q_rd.pop_front());
         end
         if (inv_v && inv_r && q_inv.size() != 0) begin
            chk_cnt++; if (inv_d !== q_inv[0]) $display("FAIL rnd_inv_data: got %h exp %h", inv_d, q_inv[0]); else pass_cnt++;
            void'(q_inv.pop_front());
         end
         if (pushes < 1000 && encoder_ready && $urandom_range(0, 3) != 0) begin
            dst = l2_out_dst_t'($urandom_range(0, 3));
            coh = 2'($urandom); hp = 1'($urandom); addr = 28'($urandom);
            line = {$urandom, $urandom, $urandom, $urandom};
            wm = 4'($urandom); id = 4'($urandom); tr = 1'($urandom);
            do_push(dst, coh, hp, addr, line, wm, id, tr);
            case (dst)
               DST_REQ:    q_req.push_back('{coh_msg: coh, hprot: hp, addr: addr, line: line, word_mask: wm});
               DST_RSP:    q_rsp.push_back('{coh_msg: coh, req_id: id, to_req: tr, addr: addr, line: line, word_mask: wm});
               DST_RD_RSP: q_rd.push_back('{line: line});
               default:    q_inv.push_back('{addr: addr, hprot: hp});
            endcase
            pushes++;
         end else begin
            idle();
         end
         step();
         cyc++;
      end
      idle();
      set_readies(4'b0000);
      chk_cnt++; if (pushes != 1000 || q_req.size() + q_rsp.size() + q_rd.size() + q_inv.size() != 0) $display("FAIL rnd_timeout: got pushes=%0d left=%0d exp 1000/0", pushes, q_req.size() + q_rsp.size() + q_rd.size() + q_inv.size()); else pass_cnt++;
      chk_cnt++; if (push_overflow !== 1'b0) $display("FAIL rnd_overflow: got %b exp 0", push_overflow); else pass_cnt++;
      chk_cnt++; if (out_drained !== 1'b1) $display("FAIL rnd_drained: got %b exp 1", out_drained); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      do_push(DST_REQ, 2'd1, 1'b1, 28'hA1, 128'hA1, 4'h1, 4'd0, 1'b0);
      step();
      do_push(DST_REQ, 2'd1, 1'b1, 28'hA2, 128'hA2, 4'h1, 4'd0, 1'b0);
      step();
      idle();
      chk_cnt++; if (req_v !== 1'b1) $display("FAIL rstmid_pending: got %b exp 1", req_v); else pass_cnt++;
      rst = 1'b0;
      #1;
      chk_cnt++; if (req_v !== 1'b0) $display("FAIL rstmid_async_valid: got %b exp 0", req_v); else pass_cnt++;
      chk_cnt++; if (req_d !== '0) $display("FAIL rstmid_async_data: got %h exp 0", req_d); else pass_cnt++;
      chk_cnt++; if (push_overflow !== 1'b0) $display("FAIL rstmid_overflow: got %b exp 0", push_overflow); else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      set_readies(4'b1111);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_cnt++; if (req_v !== 1'b0) $display("FAIL rstmid_no_replay: got %b exp 0 cycle %0d", req_v, i); else pass_cnt++;
      end
      chk_cnt++; if (out_drained !== 1'b1 || encoder_ready !== 1'b1) $display("FAIL rstmid_status: got %b%b exp 11", out_drained, encoder_ready); else pass_cnt++;
      set_readies(4'b0000);
   endtask

   initial begin
      test_reset();
      test_basic_req();
      test_rsp_backpressure();
      test_back_to_back();
      test_random();
      test_overflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
